// File: rtl/pulse_pair_meter.sv
// Measures a periodic double-pulse train on an asynchronous pin: pulse-1 width,
// inter-pulse gap, pulse-2 width and frame period, all in clk cycles.
`timescale 1ns/1ps
module pulse_pair_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [CNT_W-1:0] width1,
  output logic [CNT_W-1:0] delay,
  output logic [CNT_W-1:0] width2,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {ARM, IDLE, P1, GAP, P2, TAIL} state_t;

  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic                   prev_q;
  logic                   s, rise, fall, sync_full;

  state_t                 state_q;
  logic [CNT_W-1:0]       w1_q, dl_q, w2_q, per_q;
  logic [CNT_W-1:0]       width1_q, delay_q, width2_q, period_q;
  logic                   meas_valid_q, timeout_err_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  // fill_q marks when s first reflects a post-reset pin sample, so ARM never
  // mistakes the reset-zeroed chain for a real low level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= s;
    end
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign sync_full = fill_q[SYNC_STAGES-1];
  assign rise      = s & ~prev_q;
  assign fall      = ~s & prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARM;
      w1_q          <= '0;
      dl_q          <= '0;
      w2_q          <= '0;
      per_q         <= '0;
      width1_q      <= '0;
      delay_q       <= '0;
      width2_q      <= '0;
      period_q      <= '0;
      meas_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      meas_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      if (clear) begin
        state_q <= ARM;
        w1_q    <= '0;
        dl_q    <= '0;
        w2_q    <= '0;
        per_q   <= '0;
      end else begin
        case (state_q)
          ARM:  if (sync_full && !s) state_q <= IDLE;
          IDLE: if (rise) begin
            state_q <= P1;
            w1_q    <= ONE;
            per_q   <= ONE;
          end
          default: begin
            // Timeout is tested before any edge, so a TAIL rise landing on the
            // timeout cycle is discarded with the frame.
            if (per_q >= TO_VAL) begin
              timeout_err_q <= 1'b1;
              state_q       <= ARM;
              w1_q          <= '0;
              dl_q          <= '0;
              w2_q          <= '0;
              per_q         <= '0;
            end else begin
              per_q <= sat_inc(per_q);
              case (state_q)
                P1: if (fall) begin
                  state_q <= GAP;
                  dl_q    <= ONE;
                end else w1_q <= sat_inc(w1_q);
                GAP: if (rise) begin
                  state_q <= P2;
                  w2_q    <= ONE;
                end else dl_q <= sat_inc(dl_q);
                P2: if (fall) state_q <= TAIL;
                    else      w2_q    <= sat_inc(w2_q);
                TAIL: if (rise) begin
                  width1_q     <= w1_q;
                  delay_q      <= dl_q;
                  width2_q     <= w2_q;
                  period_q     <= per_q;
                  meas_valid_q <= 1'b1;
                  state_q      <= P1;
                  w1_q         <= ONE;
                  per_q        <= ONE;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign width1      = width1_q;
  assign delay       = delay_q;
  assign width2      = width2_q;
  assign period      = period_q;
  assign meas_valid  = meas_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pulse_pair_meter.sv
// Bench for pulse_pair_meter: an edge-timestamp frame model checked every
// cycle, plus literal expectations for each directed scenario.
`timescale 1ns/1ps
module tb_pulse_pair_meter;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 3000;
  localparam int SYNC    = 2;

  logic clk = 1'b0, rst_n = 1'b0, pulse_in = 1'b0, clear = 1'b0;
  logic [CNT_W-1:0] width1, delay, width2, period;
  logic meas_valid, timeout_err;

  pulse_pair_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear),
    .width1(width1), .delay(delay), .width2(width2), .period(period),
    .meas_valid(meas_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, mv_cnt = 0, to_cnt = 0, t_to = 0;
  int mv0, to0, t_rise;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: pin samples delayed by the synchronizer depth, frames tracked as
  // edge timestamps (r1 rise, f1 fall, r2 rise, f2 fall, next rise closes).
  bit q[$];
  bit need_low = 1'b1, active = 1'b0, pv = 1'b0;
  int j = 0, r1 = 0, f1 = 0, r2 = 0, f2 = 0, ph = 0;
  logic [CNT_W-1:0] e_w1 = '0, e_dl = '0, e_w2 = '0, e_per = '0;
  bit e_mv = 1'b0, e_to = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit v;
    if (!rst_n) begin
      q.delete();
      need_low = 1'b1; active = 1'b0; pv = 1'b0; j = 0; ph = 0;
      e_w1 = '0; e_dl = '0; e_w2 = '0; e_per = '0; e_mv = 1'b0; e_to = 1'b0;
    end else begin
      cyc++;
      e_mv = 1'b0; e_to = 1'b0;
      q.push_back(pulse_in);
      if (q.size() > SYNC) begin
        v = q.pop_front();
        if (clear) begin
          need_low = 1'b1; active = 1'b0;
        end else if (need_low) begin
          if (!v) need_low = 1'b0;
        end else if (active && (j - r1) >= TIMEOUT) begin
          e_to = 1'b1; active = 1'b0; need_low = 1'b1;
        end else if (active) begin
          if (!v && pv && ph == 0) begin f1 = j; ph = 1; end
          else if (v && !pv && ph == 1) begin r2 = j; ph = 2; end
          else if (!v && pv && ph == 2) begin f2 = j; ph = 3; end
          else if (v && !pv && ph == 3) begin
            e_w1 = CNT_W'(f1 - r1); e_dl = CNT_W'(r2 - f1);
            e_w2 = CNT_W'(f2 - r2); e_per = CNT_W'(j - r1);
            e_mv = 1'b1; r1 = j; ph = 0;
          end
        end else if (v && !pv) begin
          active = 1'b1; r1 = j; ph = 0;
        end
        pv = v;
        j++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outputs", {width1, delay}, 64'd0);
      chk("rst_outputs2", {width2, period}, 64'd0);
      chk("rst_strobes", {meas_valid, timeout_err}, 64'd0);
    end else begin
      chk("meas_valid", meas_valid, e_mv);
      chk("timeout_err", timeout_err, e_to);
      chk("width1", width1, e_w1);
      chk("delay", delay, e_dl);
      chk("width2", width2, e_w2);
      chk("period", period, e_per);
      if (meas_valid) mv_cnt++;
      if (timeout_err) begin to_cnt++; t_to = cyc; end
    end
  end

  task automatic hold(input bit v, input int n);
    repeat (n) begin @(negedge clk); pulse_in = v; end
  endtask

  task automatic frame(input int h1, input int lo, input int h2, input int per);
    hold(1'b1, h1); hold(1'b0, lo); hold(1'b1, h2); hold(1'b0, per - h1 - lo - h2);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_width1", width1, 0);
    chk("async_rst_delay", delay, 0);
    chk("async_rst_width2", width2, 0);
    chk("async_rst_period", period, 0);
    chk("async_rst_strobes", {meas_valid, timeout_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_res(input string tag, input int w1, input int dl, input int w2, input int per);
    chk({tag, "_width1"}, width1, w1);
    chk({tag, "_delay"}, delay, dl);
    chk({tag, "_width2"}, width2, w2);
    chk({tag, "_period"}, period, per);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_width1", width1, 0);
    chk("reset_period", period, 0);
    rst_n = 1'b1;

    // Generator-shaped train, period scaled to fit the bench timeout
    hold(1'b0, 10);
    mv0 = mv_cnt; to0 = to_cnt;
    repeat (3) frame(30, 200, 60, 2001);
    chk("t1_mv_count", mv_cnt - mv0, 2);
    chk("t1_to_count", to_cnt - to0, 0);
    chk_res("t1", 30, 200, 60, 2001);
    hold(1'b0, 1200);
    chk("t1_tail_timeout", to_cnt - to0, 1);
    chk_res("t1_held", 30, 200, 60, 2001);

    // Reset released mid-pulse
    hold(1'b1, 5);
    do_reset();
    mv0 = mv_cnt;
    hold(1'b1, 20); hold(1'b0, 50);
    chk("t2_no_early", mv_cnt - mv0, 0);
    repeat (2) frame(5, 7, 9, 40);
    hold(1'b1, 3); hold(1'b0, 6);
    chk("t2_mv_count", mv_cnt - mv0, 2);
    chk_res("t2", 5, 7, 9, 40);

    // Single pulse then silence
    do_reset();
    mv0 = mv_cnt; to0 = to_cnt;
    hold(1'b0, 5);
    @(negedge clk); pulse_in = 1'b1; t_rise = cyc + 1;
    hold(1'b1, 29); hold(1'b0, TIMEOUT + 50);
    chk("t3_to_count", to_cnt - to0, 1);
    chk("t3_to_latency", t_to - t_rise, TIMEOUT + SYNC);
    chk("t3_mv_count", mv_cnt - mv0, 0);
    chk_res("t3", 0, 0, 0, 0);

    // Minimal 1/1/1/1 frames
    do_reset();
    mv0 = mv_cnt;
    hold(1'b0, 5);
    repeat (6) frame(1, 1, 1, 4);
    hold(1'b1, 1); hold(1'b0, 10);
    chk("t4_mv_count", mv_cnt - mv0, 6);
    chk_res("t4", 1, 1, 1, 4);

    // Clear during GAP
    do_reset();
    mv0 = mv_cnt;
    hold(1'b0, 5);
    frame(4, 6, 8, 30);
    hold(1'b1, 5); hold(1'b0, 3);
    @(negedge clk); clear = 1'b1; pulse_in = 1'b0;
    @(negedge clk); clear = 1'b0;
    hold(1'b0, 40);
    chk("t5_mv_before", mv_cnt - mv0, 1);
    chk_res("t5_held", 4, 6, 8, 30);
    frame(5, 7, 9, 40);
    hold(1'b1, 2); hold(1'b0, 6);
    chk("t5_mv_count", mv_cnt - mv0, 2);
    chk_res("t5", 5, 7, 9, 40);

    // Reset mid-P2
    do_reset();
    hold(1'b0, 5);
    frame(4, 6, 8, 30);
    hold(1'b1, 5); hold(1'b0, 7); hold(1'b1, 4);
    chk_res("t6_pre", 4, 6, 8, 30);
    do_reset();
    mv0 = mv_cnt;
    hold(1'b1, 3); hold(1'b0, 20);
    repeat (2) frame(5, 7, 9, 40);
    hold(1'b1, 2); hold(1'b0, 6);
    chk("t6_mv_count", mv_cnt - mv0, 2);
    chk_res("t6", 5, 7, 9, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pulse_pair_meter.md
Name: pulse_pair_meter

Overview:
- Receive-side counterpart to the two-pulse generator: measures a periodic double-pulse train arriving on a single pin.
- Reports first-pulse width, inter-pulse delay, second-pulse width and frame period, all in clk cycles.
- Sits at the top level beside the pulse generator, e.g. on a loopback pin, so the board can self-check programmed timing.
- Results are registered and accompanied by a one-cycle valid strobe.

Parameters:
- CNT_W, 32, width of every measurement counter and result output.
- TIMEOUT, 1000000, frame abort threshold in cycles, measured from the first-pulse rise; must be < 2^CNT_W.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer (>= 2).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is used synchronously.
- pulse_in  in  1  asynchronous pulse train from the pin.
- clear  in  1  synchronous; returns the FSM to ARM and zeroes working counters, leaving result registers intact.
- width1  out  CNT_W  high cycles of pulse 1.
- delay  out  CNT_W  low cycles between pulse-1 fall and pulse-2 rise.
- width2  out  CNT_W  high cycles of pulse 2.
- period  out  CNT_W  cycles from pulse-1 rise to the next pulse-1 rise.
- meas_valid  out  1  one-cycle strobe; all four results are updated in the same cycle.
- timeout_err  out  1  one-cycle strobe when a frame is aborted.

Behaviour:
- Reset (rst_n=0): all outputs 0, synchronizer flops 0, FSM = ARM, counters 0.
- Synchronizer: pulse_in passes through SYNC_STAGES flops to give s. A prev register holds s delayed one cycle.
  - rise = s & ~prev; fall = ~s & prev.
  - Result latency is SYNC_STAGES+1 cycles after the frame-closing pin edge.
- Measurement definition: each result is the number of clk cycles in which s held the relevant level. A clean generator pulse of N high cycles therefore yields N.
- FSM states:
  - ARM: wait for s=0. This guarantees no measurement starts mid-pulse after reset or clear. Go to IDLE.
  - IDLE: on rise, go to P1; w1 := 1, per := 1.
  - P1: while s=1, w1++. On fall, go to GAP; dl := 1.
  - GAP: while s=0, dl++. On rise, go to P2; w2 := 1.
  - P2: while s=1, w2++. On fall, go to TAIL.
  - TAIL: wait for rise. On rise:
    - load width1 := w1, delay := dl, width2 := w2, period := per;
    - pulse meas_valid;
    - go to P1 with w1 := 1, per := 1, so back-to-back frames lose no edge.
- per increments every cycle in P1, GAP, P2 and TAIL.
- Timeout: in P1, GAP, P2 or TAIL, when per reaches TIMEOUT:
  - pulse timeout_err;
  - go to ARM;
  - result registers hold their previous values and meas_valid does not fire.
- Counters saturate at 2^CNT_W-1 and never wrap. Timeout normally fires first.
- Simultaneous clear and edge: clear wins, the edge is ignored, and the FSM goes to ARM.
- Simultaneous timeout and TAIL rise: the timeout wins, so the frame is discarded.
- rst_n asserted mid-frame: everything returns to reset values immediately, without waiting for clk.
- meas_valid and timeout_err are never high in the same cycle.
- Outputs are registered, with no combinational path from pulse_in.

Test Plan:
1. Generator-shaped train with 30 high / 200 low / 60 high and a 200001-cycle frame, repeated 3 frames -> meas_valid fires twice (after frames 1 and 2 close) with width1=30, delay=200, width2=60, period=200001; timeout_err stays 0.
2. Reset released while pulse_in=1 mid-pulse -> no measurement until pulse_in goes low. The first valid report then carries exact values from the next full frame.
3. Single pulse (width 30) then silence -> exactly one timeout_err strobe 1000000 cycles after the rise is seen at s. FSM returns to ARM; results stay 0.
4. Minimal frame of 1 high, 1 low, 1 high, 1 low, repeated -> width1=1, delay=1, width2=1, period=4 on every meas_valid.
5. clear asserted during GAP, then normal frames resume -> no report for the cleared frame. The next full frame reports correct values, and earlier results are held until then.
6. rst_n pulsed low mid-P2 -> all outputs read 0 in the same cycle as rst_n falls, and measurement restarts cleanly after release.
